// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// An m-deep byte FIFO feeds a serialiser that sends frames back to back.
module uart_tx_fifo #(
    parameter int n        = 8,
    parameter int address  = 3,
    parameter int m        = 8,
    parameter int baud_div = 434
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [n-1:0]     wr_i,
    input  logic             ena_wr_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [address:0] count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             Tx_o
);
    localparam int CW = (baud_div > 1) ? $clog2(baud_div) : 1;
    localparam int BW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(baud_div - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(n - 1);
    localparam logic [address:0] M_CNT = (address + 1)'(m);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [n-1:0]       shift_q, shift_d;
    logic [address-1:0] wr_ptr_q, rd_ptr_q;
    logic [n-1:0]       mem [m];
    logic               wr_en, pop;
    logic [address:0]   count_d;
    logic               tx_d, done_d, busy_d;

    assign wr_en   = ena_wr_i && !full_o;
    assign count_d = count_o + {{address{1'b0}}, wr_en}
                             - {{address{1'b0}}, pop};

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty_o) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when data waits
                    if (!empty_o) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        tx_d = 1'b1;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shift_d[0];
        end
        done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_o  <= '0;
            full_o   <= 1'b0;
            empty_o  <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            Tx_o     <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_o <= count_d;
            full_o  <= (count_d == M_CNT);
            empty_o <= (count_d == '0);
            busy_o  <= busy_d;
            done_o  <= done_d;
            Tx_o    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo (baud_div=4, 40-cycle frames).
// A line monitor decodes frames and compares them against a byte scoreboard.
module tb_uart_tx_fifo;
    localparam int BD    = 4;
    localparam int FRAME = 10 * BD;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic [7:0] wr_i = '0;
    logic       ena_wr_i = 1'b0;
    logic       full_o, empty_o, busy_o, done_o, Tx_o;
    logic [3:0] count_o;

    uart_tx_fifo #(
        .n(8), .address(3), .m(8), .baud_div(BD)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .wr_i(wr_i),
        .ena_wr_i(ena_wr_i), .full_o(full_o), .empty_o(empty_o),
        .count_o(count_o), .busy_o(busy_o), .done_o(done_o),
        .Tx_o(Tx_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] sb[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Line monitor
    int mon_ph = -1;
    int mon_gap = 0;
    int mon_slot, mon_sub;
    bit mon_seen = 1'b0;
    logic [7:0] mon_byte;
    int frames = 0;
    int dones = 0;
    int contig = 0;
    int done_cyc = 0;

    initial forever begin
        @(negedge clk_i);
        if (!rst_ni) begin
            mon_ph = -1;
            mon_gap = 0;
            mon_seen = 1'b0;
        end else begin
            if (done_o === 1'b1) dones++;
            if (mon_ph < 0) begin
                if (Tx_o === 1'b0) begin
                    if (mon_seen && mon_gap == 0) contig++;
                    mon_ph = 0;
                end else begin
                    mon_gap++;
                    check("idle_busy", busy_o, 0);
                    check("idle_done", done_o, 0);
                end
            end
            if (mon_ph >= 0) begin
                mon_slot = mon_ph / BD;
                mon_sub = mon_ph % BD;
                check("frame_busy", busy_o, 1);
                check("frame_done", done_o, mon_ph == FRAME - 1);
                if (mon_slot == 0) begin
                    check("start_bit", Tx_o, 0);
                end else if (mon_slot == 9) begin
                    check("stop_bit", Tx_o, 1);
                end else if (mon_sub == 0) begin
                    mon_byte[mon_slot-1] = Tx_o;
                end else begin
                    check("data_hold", Tx_o, mon_byte[mon_slot-1]);
                end
                if (mon_ph == FRAME - 1) begin
                    if (sb.size() == 0) check("frame_unexpected", 1, 0);
                    else check("frame_byte", mon_byte, sb.pop_front());
                    frames++;
                    done_cyc = cyc;
                    mon_seen = 1'b1;
                    mon_gap = 0;
                    mon_ph = -1;
                end else begin
                    mon_ph++;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic wait_frames(input int target, input int budget,
                               input string name);
        int b;
        b = budget;
        while (frames < target && b > 0) begin
            step();
            b--;
        end
        check(name, frames, target);
    endtask

    function automatic logic [8:0] outv();
        return {Tx_o, full_o, empty_o, count_o, busy_o, done_o};
    endfunction

    localparam logic [8:0] RST_V = 9'b1_0_1_0000_0_0;

    typedef struct {
        bit         ena;
        logic [7:0] data;
        bit         push;
        logic [3:0] cnt;
        bit         full;
        bit         empty;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int f0, d0, c0, k, b;

        tbl[0]  = '{1'b1, 8'd0,  1'b1, 4'd1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'd1,  1'b1, 4'd1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'd2,  1'b1, 4'd2, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'd3,  1'b1, 4'd3, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'd4,  1'b1, 4'd4, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'd5,  1'b1, 4'd5, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'd6,  1'b1, 4'd6, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'd7,  1'b1, 4'd7, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'd8,  1'b1, 4'd8, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 8'd9,  1'b0, 4'd8, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 8'd10, 1'b0, 4'd8, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 8'd11, 1'b0, 4'd8, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 8'd0,  1'b0, 4'd8, 1'b1, 1'b0};

        // Reset and quiet idle
        #1 rst_ni = 1'b0;
        #1 check("reset_outputs", outv(), RST_V);
        step(); step(); step();
        rst_ni = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            check("idle_outputs", outv(), RST_V);
        end

        // Single byte 0xA5
        f0 = frames;
        ena_wr_i = 1'b1; wr_i = 8'hA5; sb.push_back(8'hA5);
        step();
        ena_wr_i = 1'b0;
        k = cyc;
        check("single_count_w", count_o, 1);
        check("single_tx_w", {Tx_o, busy_o, empty_o}, 3'b100);
        step();
        check("single_pop", {Tx_o, busy_o, empty_o, count_o}, 7'b0_1_1_0000);
        wait_frames(f0 + 1, 60, "single_frame");
        check("single_done_cyc", done_cyc - k, 40);
        step();
        check("single_after", {Tx_o, busy_o}, 2'b10);
        repeat (5) step();

        // Back-to-back frames
        f0 = frames; d0 = dones; c0 = contig;
        ena_wr_i = 1'b1; wr_i = 8'h01; sb.push_back(8'h01);
        step();
        check("b2b_cnt0", count_o, 1);
        wr_i = 8'h80; sb.push_back(8'h80);
        step();
        check("b2b_cnt1", count_o, 1);
        wr_i = 8'hFF; sb.push_back(8'hFF);
        step();
        ena_wr_i = 1'b0;
        check("b2b_cnt2", count_o, 2);
        b = 0;
        while (done_o !== 1'b1 && b < 60) begin
            step();
            b++;
        end
        check("b2b_done_seen", done_o, 1);
        check("b2b_cnt_done", count_o, 2);
        step();
        check("b2b_cnt_pop", count_o, 1);
        wait_frames(f0 + 3, 3 * FRAME + 20, "b2b_frames");
        check("b2b_contig", contig - c0, 2);
        check("b2b_dones", dones - d0, 3);
        repeat (5) step();

        // Overflow, table-driven
        f0 = frames;
        foreach (tbl[i]) begin
            ena_wr_i = tbl[i].ena;
            wr_i = tbl[i].data;
            if (tbl[i].push) sb.push_back(tbl[i].data);
            step();
            check("ovf_count", count_o, tbl[i].cnt);
            check("ovf_full", full_o, tbl[i].full);
            check("ovf_empty", empty_o, tbl[i].empty);
        end
        ena_wr_i = 1'b0;
        wait_frames(f0 + 9, 9 * FRAME + 60, "ovf_frames");
        step();
        check("ovf_drained", {empty_o, count_o, busy_o}, 6'b1_0000_0);
        repeat (5) step();

        // Write on the STOP-to-START edge
        f0 = frames;
        ena_wr_i = 1'b1; wr_i = 8'h3C; sb.push_back(8'h3C);
        step();
        wr_i = 8'hC3; sb.push_back(8'hC3);
        step();
        ena_wr_i = 1'b0;
        b = 0;
        while (done_o !== 1'b1 && b < 60) begin
            step();
            b++;
        end
        check("simul_done_seen", done_o, 1);
        check("simul_pre", count_o, 1);
        ena_wr_i = 1'b1; wr_i = 8'h5A; sb.push_back(8'h5A);
        step();
        ena_wr_i = 1'b0;
        check("simul_count", count_o, 1);
        check("simul_start", Tx_o, 0);
        wait_frames(f0 + 3, 3 * FRAME + 20, "simul_frames");
        repeat (5) step();

        // Reset during data bit 3
        ena_wr_i = 1'b1; wr_i = 8'h96; sb.push_back(8'h96);
        step();
        wr_i = 8'h11; sb.push_back(8'h11);
        step();
        ena_wr_i = 1'b0;
        repeat (17) step();
        check("mid_bit3", Tx_o, 0);
        check("mid_count", count_o, 1);
        rst_ni = 1'b0;
        #1 check("mid_reset", outv(), RST_V);
        sb.delete();
        step(); step();
        rst_ni = 1'b1;
        f0 = frames;
        repeat (60) step();
        check("mid_no_frame", frames, f0);
        check("mid_quiet", outv(), RST_V);
        ena_wr_i = 1'b1; wr_i = 8'h42; sb.push_back(8'h42);
        step();
        ena_wr_i = 1'b0;
        wait_frames(f0 + 1, 60, "mid_new_frame");
        repeat (5) step();
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
